idma_burst_drain: RTL and testbench
===================================

Name: idma_burst_drain

Overview:
- Read-side consumer for the iDMA sync datapath FIFOs: pops beats from a flushable FIFO's valid/ready output and emits them as write-data bursts (W-channel style) with a last-beat marker.
- Burst length comes from a command handshake; the block tracks beats and closes each burst exactly.
- Sits between the data FIFO read port and the write-channel master of the 256-bit iDMA engine.

Parameters:
- DATA_W, 256, beat data width.
- LEN_W, 8, burst length field width; cmd_len encodes beats-1 (AXI convention).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; same-cycle pulse as the FIFO flush
- cmd_valid  input  1  burst command valid
- cmd_len  input  LEN_W  burst beats minus 1
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- s_valid  input  1  FIFO read side has data
- s_data  input  DATA_W  FIFO read data
- s_ready  output  1  pop strobe to the FIFO
- w_valid  output  1  write beat valid
- w_data  output  DATA_W  write beat data
- w_last  output  1  final beat of the current burst
- w_ready  input  1  downstream accepts the beat
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse after the last beat handshake

Behaviour:
- Reset (rst_n low, async): state IDLE, beat_cnt=0, len_q=0, done=0. Outputs: cmd_ready=1, s_ready=0, w_valid=0, w_last=0, busy=0. w_data follows s_data.
- FSM states:
  - IDLE: on cmd handshake, capture len_q=cmd_len, clear beat_cnt=0, go to BURST.
  - BURST:
    - On each beat handshake (w_valid && w_ready), beat_cnt++.
    - On the handshake with w_last=1: assert done next cycle.
    - At that point, if a new cmd handshakes in the same cycle, reload len_q, clear beat_cnt, stay in BURST with no bubble. Otherwise go to IDLE.
- Datapath is combinational pass-through with zero latency:
  - w_valid = BURST && s_valid
  - s_ready = BURST && w_ready
  - w_data = s_data
  - w_last = BURST && (beat_cnt == len_q)
- A FIFO pop and a W beat occur in the same cycle, so beats are never duplicated or dropped.
- cmd_ready = IDLE || (BURST && w_valid && w_ready && w_last).
- busy = BURST.
- Handshake rules:
  - Once w_valid is high it must remain high, with w_data stable, until w_ready. This holds because the FIFO holds s_valid and s_data until popped.
  - cmd_len is sampled only at the cmd handshake.
- Width: beat_cnt is LEN_W bits. len_q = 2^LEN_W-1 gives a 256-beat burst with no wrap before w_last. len_q = 0 gives a single-beat burst with w_last on the first beat.
- FIFO empty mid-burst: w_valid drops, beat_cnt holds, and the burst resumes when s_valid returns.
- Downstream stall (w_ready=0): s_ready=0 and the FIFO is not popped.
- Flush has highest priority. In the flush cycle:
  - Force state IDLE, beat_cnt=0, done=0.
  - Mask cmd_ready, s_ready and w_valid to 0.
  - Discard any in-flight command and the partial burst.
  - From the next cycle the block is ready for a new command.
- Reset mid-burst: immediate return to reset values.

Optional Feature:
- Macro IDMA_DRAIN_PERF_EN.
- When defined, add two 32-bit saturating counters, cleared by reset or flush:
  - stall_cnt: output port, counts cycles with w_valid && !w_ready.
  - starve_cnt: output port, counts cycles in BURST with !s_valid.
- When undefined, neither port nor the counter logic exists. Behaviour is otherwise identical.

Test Plan:
- cmd_len=3, s_valid and w_ready held 1 -> 4 beats on consecutive cycles, w_last only on the 4th, done pulses the cycle after, busy falls, cmd_ready=1.
- Back-to-back: cmd_len=1 followed by cmd_len=0 presented at the last beat -> beats D0,D1(last),D2(last) with no idle cycle, and done pulses after D1 and after D2.
- cmd_len=7 with w_ready toggling 1,0,1,0 and s_valid dropping for 3 cycles -> exactly 8 pops and 8 beats, data order preserved, w_data stable while stalled, w_last on the 8th beat.
- cmd_len=255 -> 256 beats, w_last only when beat_cnt=255, no early wrap.
- Flush at beat 2 of cmd_len=5 -> in the flush cycle w_valid=s_ready=cmd_ready=0, no done pulse. Next cycle state is IDLE. A new cmd_len=0 then completes as a single last beat.
- Async reset asserted mid-burst -> all outputs at reset values immediately. With IDMA_DRAIN_PERF_EN defined, stall_cnt and starve_cnt read 0.

Source files
------------

// File: rtl/idma_burst_drain.sv
// idma_burst_drain: pops beats from the data FIFO read port and emits them as
// write-data bursts with a last-beat marker. Zero-latency combinational datapath.
// Backpressure: w_ready feeds straight back to s_ready. Flush aborts the burst in the same cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort, pulsed together with the FIFO flush
//   cmd_valid/ready/len   burst command handshake, len = beats-1
//   s_valid/ready/data    FIFO read side (s_ready is the pop strobe)
//   w_valid/ready/data    write-beat output, w_last marks the final beat
//   busy                  burst in progress
//   done                  one-cycle pulse after the last-beat handshake
//   stall_cnt, starve_cnt only when IDMA_DRAIN_PERF_EN is defined: saturating
//                         counts of downstream-stall and FIFO-starve cycles
module idma_burst_drain #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cmd_valid,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_ready,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last,
    input  logic              w_ready,
    output logic              busy,
    output logic              done
`ifdef IDMA_DRAIN_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       starve_cnt
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               done_q, done_d;

    logic               in_burst;
    logic               beat_hs;
    logic               last_hs;
    logic               cmd_hs;

`ifdef IDMA_DRAIN_PERF_EN
    logic [31:0]        stall_cnt_q, starve_cnt_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            done_q     <= done_d;
        end
    end

`ifdef IDMA_DRAIN_PERF_EN
    // Saturating performance counters; flush clears them with the burst state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else if (flush) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (w_valid && !w_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (in_burst && !s_valid && (starve_cnt_q != 32'hFFFF_FFFF)) begin
                starve_cnt_q <= starve_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign starve_cnt = starve_cnt_q;
`endif

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        done_d     = 1'b0;
        if (flush) begin
            // Abort wins over everything: drop the partial burst and any command.
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        state_d    = ST_BURST;
                        len_d      = cmd_len;
                        beat_cnt_d = '0;
                    end
                end
                ST_BURST: begin
                    if (beat_hs) begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                    if (last_hs) begin
                        done_d = 1'b1;
                        // A command accepted on the last beat chains the next
                        // burst without an idle cycle.
                        if (cmd_hs) begin
                            len_d      = cmd_len;
                            beat_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: the beat is the FIFO pop, so both sides share one handshake.
    always_comb begin
        in_burst  = (state_q == ST_BURST);
        w_valid   = in_burst && s_valid && !flush;
        s_ready   = in_burst && w_ready && !flush;
        w_data    = s_data;
        w_last    = in_burst && (beat_cnt_q == len_q);
        beat_hs   = w_valid && w_ready;
        last_hs   = beat_hs && w_last;
        cmd_ready = !flush && (!in_burst || last_hs);
        cmd_hs    = cmd_valid && cmd_ready;
        busy      = in_burst;
        done      = done_q;
    end

endmodule

// File: tb/tb_idma_burst_drain.sv
// tb_idma_burst_drain: directed bench with a FIFO source model and a beat scoreboard.
// Latency: checks zero-cycle pass-through and done one cycle after the last beat.
// Backpressure: drives w_ready toggling and FIFO starvation gaps.
module tb_idma_burst_drain;

    typedef struct packed {
        logic [255:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         cmd_valid;
    logic [7:0]   cmd_len;
    logic         cmd_ready;
    logic         s_valid;
    logic [255:0] s_data;
    logic         s_ready;
    logic         w_valid;
    logic [255:0] w_data;
    logic         w_last;
    logic         w_ready;
    logic         busy;
    logic         done;
`ifdef IDMA_DRAIN_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  starve_cnt;
`endif

    always #5 clk = ~clk;

    idma_burst_drain #(.DATA_W(256), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_last    (w_last),
        .w_ready   (w_ready),
        .busy      (busy),
        .done      (done)
`ifdef IDMA_DRAIN_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .starve_cnt(starve_cnt)
`endif
    );

    int n_asserts = 0;
    int n_fail    = 0;

    logic [255:0] src[$];
    beat_t        exp_q[$];
    logic [7:0]   cmdq[$];

    int           cyc = 0;
    int           n_beats, n_pops, done_cnt, first_hs, last_hs_cyc;
    int           starve_left = 0;
    int           starve_at = -1;
    bit           wr_toggle = 1'b0;
    bit           prev_stall = 1'b0;
    logic [255:0] prev_data = '0;
    logic         exp_done_next = 1'b0;
    logic         o_wv, o_sr, o_cr, o_busy;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr_stats();
        n_beats = 0; n_pops = 0; done_cnt = 0; first_hs = -1; last_hs_cyc = -1;
    endtask

    // Queue one command plus its len+1 FIFO beats and the expected W beats.
    task automatic push_burst(input int len);
        logic [255:0] d;
        beat_t        b;
        cmdq.push_back(8'(len));
        for (int i = 0; i <= len; i++) begin
            for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
            src.push_back(d);
            b.data = d;
            b.last = (i == len);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle: drive at posedge+1, sample at posedge+4, commit after the edge.
    task automatic step();
        bit    gate, hs, pop, c_hs;
        beat_t item;
        if (wr_toggle) w_ready = cyc[0];
        if (starve_at >= 0 && n_beats == starve_at) begin
            starve_left = 3;
            starve_at   = -1;
        end
        gate = 1'b1;
        // A real FIFO never withdraws a presented beat, so starve only when not stalled.
        if (starve_left > 0 && !prev_stall) begin
            gate = 1'b0;
            starve_left--;
        end
        s_valid   = gate && (src.size() > 0);
        s_data    = (src.size() > 0) ? src[0] : '0;
        cmd_valid = (cmdq.size() > 0);
        cmd_len   = (cmdq.size() > 0) ? cmdq[0] : 8'd0;
        #3;
        o_wv = w_valid; o_sr = s_ready; o_cr = cmd_ready; o_busy = busy;
        chk("done_pulse", done, exp_done_next);
        if (done === 1'b1) done_cnt++;
        if (prev_stall) begin
            chk("stall_hold_valid", w_valid, 1'b1);
            chk("stall_hold_data", w_data, prev_data);
        end
        hs  = (w_valid === 1'b1) && (w_ready === 1'b1);
        pop = (s_valid === 1'b1) && (s_ready === 1'b1);
        chk("pop_equals_beat", pop, hs);
        exp_done_next = 1'b0;
        if (hs) begin
            chk("beat_expected", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                chk("w_data", w_data, item.data);
                chk("w_last", w_last, item.last);
                exp_done_next = item.last && !flush;
            end
            n_beats++;
            if (first_hs < 0) first_hs = cyc;
            last_hs_cyc = cyc;
        end
        prev_stall = (w_valid === 1'b1) && (w_ready === 1'b0);
        prev_data  = w_data;
        c_hs = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(src.pop_front());
            n_pops++;
        end
        if (c_hs) void'(cmdq.pop_front());
        cyc++;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while ((o_busy || cmdq.size() > 0 || exp_q.size() > 0) && k < budget);
        chk(tag, (k >= budget), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        s_valid = 1'b0; w_ready = 1'b1;
        s_data = {8{32'hA5C3_0F01}};
        #2;
        // Reset values
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_w_last", w_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_w_data_passthru", w_data, s_data);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 4-beat burst, continuous flow
        clr_stats();
        push_burst(3);
        run_until_idle("t1_timeout", 40);
        chk("t1_beats", n_beats, 4);
        chk("t1_consecutive", last_hs_cyc - first_hs, 3);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_fell", o_busy, 1'b0);
        chk("t1_cmd_ready", o_cr, 1'b1);

        // Back-to-back: len 1 then len 0 accepted on the last beat
        clr_stats();
        push_burst(1);
        push_burst(0);
        run_until_idle("t2_timeout", 40);
        chk("t2_beats", n_beats, 3);
        chk("t2_no_bubble", last_hs_cyc - first_hs, 2);
        chk("t2_done_cnt", done_cnt, 2);

        // 8 beats with w_ready toggling and a 3-cycle FIFO gap
        clr_stats();
        wr_toggle = 1'b1;
        starve_at = 3;
        push_burst(7);
        run_until_idle("t3_timeout", 80);
        wr_toggle = 1'b0;
        w_ready = 1'b1;
        chk("t3_beats", n_beats, 8);
        chk("t3_pops", n_pops, 8);
        chk("t3_done_cnt", done_cnt, 1);

        // Maximum length burst: 256 beats, no early wrap
        clr_stats();
        push_burst(255);
        run_until_idle("t4_timeout", 600);
        chk("t4_beats", n_beats, 256);
        chk("t4_done_cnt", done_cnt, 1);

        // Flush at beat 2 of a 6-beat burst
        clr_stats();
        push_burst(5);
        for (int k = 0; k < 20 && n_beats < 2; k++) step();
        chk("t5_reach_beat2", n_beats, 2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        src.delete();
        exp_q.delete();
        cmdq.delete();
        chk("t5_flush_w_valid", o_wv, 1'b0);
        chk("t5_flush_s_ready", o_sr, 1'b0);
        chk("t5_flush_cmd_ready", o_cr, 1'b0);
        step();
        chk("t5_idle_busy", o_busy, 1'b0);
        chk("t5_idle_cmd_ready", o_cr, 1'b1);
        chk("t5_no_done", done_cnt, 0);
        clr_stats();
        push_burst(0);
        run_until_idle("t5b_timeout", 20);
        chk("t5_single_beats", n_beats, 1);
        chk("t5_single_done", done_cnt, 1);

        // Asynchronous reset mid-burst
        clr_stats();
        push_burst(3);
        for (int k = 0; k < 20 && n_beats < 2; k++) step();
        chk("t6_reach_beat2", n_beats, 2);
        s_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_cmd_ready", cmd_ready, 1'b1);
        chk("t6_s_ready", s_ready, 1'b0);
        chk("t6_w_valid", w_valid, 1'b0);
        chk("t6_w_last", w_last, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
`ifdef IDMA_DRAIN_PERF_EN
        chk("t6_stall_cnt", stall_cnt, 32'd0);
        chk("t6_starve_cnt", starve_cnt, 32'd0);
`endif
        src.delete();
        exp_q.delete();
        cmdq.delete();
        s_valid = 1'b0;
        prev_stall = 1'b0;
        exp_done_next = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clr_stats();
        push_burst(0);
        run_until_idle("t6b_timeout", 20);
        chk("t6_after_reset_beats", n_beats, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
